// File: rtl/term_count_accum_if.sv
// Valid/ready stream bundle for term_count_accum: term-vector beats in, frame totals out.
interface term_count_accum_if #(
  parameter int N_LANE = 4,
  parameter int SUM_W  = 8,
  parameter int BEAT_W = 6
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_last;
  logic [10*N_LANE-1:0]  in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [SUM_W-1:0]      out_sum;
  logic [BEAT_W-1:0]     out_beats;
  logic                  out_sat;

  modport master (
    output in_valid, in_last, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_beats, out_sat
  );

  modport slave (
    input  in_valid, in_last, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_beats, out_sat
  );
endinterface

// File: rtl/term_count_accum.sv
// Evaluates three product/sum terms on N_LANE 10-bit lanes per beat and
// accumulates the asserted-term count over a frame into one saturating total.
module term_count_accum #(
  parameter int N_LANE = 4,
  parameter int SUM_W  = 8,
  parameter int BEAT_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  term_count_accum_if.slave  bus
);

  localparam int BSUM_W = $clog2(3 * N_LANE + 1);
  localparam int ADD_W  = ((SUM_W > BSUM_W) ? SUM_W : BSUM_W) + 1;
  localparam logic [ADD_W-1:0] SUM_MAX = ADD_W'({SUM_W{1'b1}});

  typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_e;

  state_e              state_q, state_d;
  logic                s1_valid_q, s1_valid_d;
  logic                s1_last_q, s1_last_d;
  logic [BSUM_W-1:0]   s1_sum_q, s1_sum_d;
  logic [SUM_W-1:0]    acc_q, acc_d;
  logic [BEAT_W-1:0]   cnt_q, cnt_d;
  logic                sat_q, sat_d;
  logic [SUM_W-1:0]    out_sum_q, out_sum_d;
  logic [BEAT_W-1:0]   out_beats_q, out_beats_d;
  logic                out_sat_q, out_sat_d;

  logic [BSUM_W-1:0]   beat_sum;
  logic [9:0]          lane;
  logic                t0, t1, t2;
  logic [1:0]          lane_cnt;
  logic [ADD_W-1:0]    sum_ext;
  logic                over;
  logic [SUM_W-1:0]    sum_sat;
  logic [BEAT_W-1:0]   cnt_inc;
  logic                accept;

  // Lane bits are {j,i,h,g,f,e,d,c,b,a} with a at bit 0.
  always_comb begin
    beat_sum = '0;
    lane     = '0;
    t0       = 1'b0;
    t1       = 1'b0;
    t2       = 1'b0;
    lane_cnt = '0;
    for (int k = 0; k < N_LANE; k++) begin
      lane     = bus.in_data[10*k +: 10];
      t0       = (lane[0] | lane[1]) & lane[2] & lane[3];
      t1       = lane[8] & lane[9];
      t2       = (lane[4] ^ lane[5]) | lane[6] | lane[7];
      lane_cnt = 2'(t0) + 2'(t1) + 2'(t2);
      beat_sum = beat_sum + BSUM_W'(lane_cnt);
    end
  end

  always_comb begin
    sum_ext = ADD_W'(acc_q) + ADD_W'(s1_sum_q);
    over    = (sum_ext > SUM_MAX);
    sum_sat = over ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
    cnt_inc = (&cnt_q) ? cnt_q : cnt_q + BEAT_W'(1);
  end

  assign bus.in_ready  = (state_q == ACCUM);
  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_sum   = out_sum_q;
  assign bus.out_beats = out_beats_q;
  assign bus.out_sat   = out_sat_q;

  always_comb begin
    state_d     = state_q;
    s1_valid_d  = accept;
    s1_last_d   = accept & bus.in_last;
    s1_sum_d    = beat_sum;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sat_d       = sat_q;
    out_sum_d   = out_sum_q;
    out_beats_d = out_beats_q;
    out_sat_d   = out_sat_q;

    if (s1_valid_q) begin
      if (s1_last_q) begin
        out_sum_d   = sum_sat;
        out_beats_d = cnt_inc;
        out_sat_d   = sat_q | over;
        acc_d       = '0;
        cnt_d       = '0;
        sat_d       = 1'b0;
      end else begin
        acc_d = sum_sat;
        cnt_d = cnt_inc;
        sat_d = sat_q | over;
      end
    end

    case (state_q)
      ACCUM:   if (accept && bus.in_last) state_d = DRAIN;
      DRAIN:   state_d = HOLD;
      HOLD:    if (bus.out_ready) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase

    // Abort wins over everything, including a result that would load this edge.
    if (clr) begin
      state_d     = ACCUM;
      s1_valid_d  = 1'b0;
      s1_last_d   = 1'b0;
      acc_d       = '0;
      cnt_d       = '0;
      sat_d       = 1'b0;
      out_sum_d   = out_sum_q;
      out_beats_d = out_beats_q;
      out_sat_d   = out_sat_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_sum_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      out_sum_q   <= '0;
      out_beats_q <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_sum_q    <= s1_sum_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      out_sum_q   <= out_sum_d;
      out_beats_q <= out_beats_d;
      out_sat_q   <= out_sat_d;
    end
  end

endmodule

// File: tb/tb_term_count_accum.sv
// Self-checking bench for term_count_accum: table of frames, corner sequences,
// then random frames against a frame-level arithmetic model.
module tb_term_count_accum;

  localparam int N_LANE = 4;
  localparam int SUM_W  = 8;
  localparam int BEAT_W = 6;
  localparam logic [39:0] ONES = 40'hFF_FFFF_FFFF;
  localparam logic [39:0] E4   = {4{10'h010}};
  localparam logic [39:0] MIX  = {10'h000, 10'h010, 10'h300, 10'h00D};

  logic clk = 1'b0;
  logic rst_n;
  logic clr;

  always #5 clk = ~clk;

  term_count_accum_if #(.N_LANE(N_LANE), .SUM_W(SUM_W), .BEAT_W(BEAT_W)) bus ();

  term_count_accum #(.N_LANE(N_LANE), .SUM_W(SUM_W), .BEAT_W(BEAT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus)
  );

  typedef struct {
    int          n;
    logic [39:0] data;
    int          exp_sum;
    int          exp_beats;
    bit          exp_sat;
  } vec_t;

  vec_t vecs[6];
  int checks   = 0;
  int failures = 0;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic l, input logic [39:0] d);
    bus.in_valid = v;
    bus.in_last  = l;
    bus.in_data  = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Number of asserted terms in one beat, straight from the term equations.
  function automatic int ref_beat(input logic [39:0] dv);
    int s = 0;
    for (int k = 0; k < 4; k++) begin
      logic [9:0] ln;
      ln = dv[10*k +: 10];
      s += int'((ln[0] | ln[1]) & ln[2] & ln[3]);
      s += int'(ln[8] & ln[9]);
      s += int'((ln[4] ^ ln[5]) | ln[6] | ln[7]);
    end
    return s;
  endfunction

  task automatic runFrame(input int n, input bit rnd, input logic [39:0] fixed,
                          input int hold, input bit consume,
                          output int total, output logic [31:0] gs,
                          output logic [31:0] gb, output logic [31:0] gsat);
    int b = 0;
    int cyc = 0;
    logic [63:0] r;
    logic [39:0] dv;
    total = 0;
    while (b < n) begin
      if (rnd && $urandom_range(0, 3) == 0) begin
        applyStimulus(1'b0, 1'b0, '0);
      end else begin
        r  = {$urandom, $urandom};
        dv = rnd ? r[39:0] : fixed;
        applyStimulus(1'b1, (b == n - 1), dv);
        checkOutput("in_ready_accum", 32'(bus.in_ready), 32'd1);
        total += ref_beat(dv);
        b++;
      end
      tick();
    end
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("drain_in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("drain_out_valid", 32'(bus.out_valid), 32'd0);
    do begin
      tick();
      cyc++;
    end while (!bus.out_valid && cyc < 8);
    checkOutput("latency_edges", 32'(cyc), 32'd1);
    gs   = 32'(bus.out_sum);
    gb   = 32'(bus.out_beats);
    gsat = 32'(bus.out_sat);
    for (int h = 0; h < hold; h++) begin
      checkOutput("hold_in_ready", 32'(bus.in_ready), 32'd0);
      checkOutput("hold_out_sum", 32'(bus.out_sum), gs);
      tick();
    end
    if (consume) begin
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      checkOutput("post_hs_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("post_hs_in_ready", 32'(bus.in_ready), 32'd1);
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int total;
    logic [31:0] gs, gb, gsat;

    vecs[0] = '{1,  ONES, 12,  1,  1'b0};
    vecs[1] = '{3,  MIX,  9,   3,  1'b0};
    vecs[2] = '{22, ONES, 255, 22, 1'b1};
    vecs[3] = '{1,  E4,   4,   1,  1'b0};
    vecs[4] = '{2,  '0,   0,   2,  1'b0};
    vecs[5] = '{70, E4,   255, 63, 1'b1};

    clr = 1'b0;
    bus.out_ready = 1'b0;
    applyStimulus(1'b0, 1'b0, '0);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_out_sum", 32'(bus.out_sum), 32'd0);
    checkOutput("rst_out_beats", 32'(bus.out_beats), 32'd0);
    checkOutput("rst_out_sat", 32'(bus.out_sat), 32'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 6; i++) begin
      runFrame(vecs[i].n, 1'b0, vecs[i].data, 1, 1'b1, total, gs, gb, gsat);
      checkOutput("tbl_sum", gs, 32'(vecs[i].exp_sum));
      checkOutput("tbl_beats", gb, 32'(vecs[i].exp_beats));
      checkOutput("tbl_sat", gsat, 32'(vecs[i].exp_sat));
    end

    // Long HOLD with ignored input pulses.
    runFrame(2, 1'b0, ONES, 0, 1'b0, total, gs, gb, gsat);
    checkOutput("hold_sum", gs, 32'd24);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(i[0], 1'b1, ONES);
      checkOutput("hold5_in_ready", 32'(bus.in_ready), 32'd0);
      checkOutput("hold5_out_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("hold5_out_sum", 32'(bus.out_sum), 32'd24);
      checkOutput("hold5_out_beats", 32'(bus.out_beats), 32'd2);
      tick();
    end
    applyStimulus(1'b0, 1'b0, '0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checkOutput("hold5_release_in_ready", 32'(bus.in_ready), 32'd1);
    runFrame(1, 1'b0, E4, 1, 1'b1, total, gs, gb, gsat);
    checkOutput("after_hold_sum", gs, 32'd4);
    checkOutput("after_hold_beats", gb, 32'd1);

    // Abort mid-frame; the beat presented with clr is dropped.
    applyStimulus(1'b1, 1'b0, ONES);
    tick();
    tick();
    clr = 1'b1;
    applyStimulus(1'b1, 1'b1, ONES);
    tick();
    clr = 1'b0;
    applyStimulus(1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("clr_no_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("clr_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
    end
    runFrame(1, 1'b0, E4, 1, 1'b1, total, gs, gb, gsat);
    checkOutput("clr_next_sum", gs, 32'd4);
    checkOutput("clr_next_beats", gb, 32'd1);
    checkOutput("clr_next_sat", gsat, 32'd0);

    // Reset while holding a result.
    runFrame(1, 1'b0, ONES, 0, 1'b0, total, gs, gb, gsat);
    checkOutput("prerst_sum", gs, 32'd12);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("async_rst_out_sum", 32'(bus.out_sum), 32'd0);
    checkOutput("async_rst_out_beats", 32'(bus.out_beats), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("rel_in_ready", 32'(bus.in_ready), 32'd1);
    runFrame(2, 1'b0, ONES, 1, 1'b1, total, gs, gb, gsat);
    checkOutput("rel_sum", gs, 32'd24);
    checkOutput("rel_beats", gb, 32'd2);

    // Random frames against the frame-level model.
    for (int f = 0; f < 30; f++) begin
      int n;
      n = $urandom_range(1, 30);
      runFrame(n, 1'b1, '0, $urandom_range(0, 3), 1'b1, total, gs, gb, gsat);
      checkOutput("rnd_sum", gs, 32'((total > 255) ? 255 : total));
      checkOutput("rnd_beats", gb, 32'((n > 63) ? 63 : n));
      checkOutput("rnd_sat", gsat, 32'(total > 255));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/term_count_accum.md
Name: term_count_accum

Overview:
- Sequential, parametrised successor of the team's 10-input combinational term-logic netlist.
- Evaluates the same three product/sum terms on N_LANE parallel 10-bit lanes per beat and sums the asserted terms across lanes.
- Accumulates those sums over a multi-beat frame and presents one saturating total per frame.
- Input and output are both valid/ready streams; sits between a term-vector source and the scoring logic downstream.

Parameters:
N_LANE, 4, number of 10-bit lanes evaluated per beat (1..16)
SUM_W, 8, width of frame accumulator and out_sum
BEAT_W, 6, width of per-frame beat counter

Ports:
clk  input  1  single clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous frame abort / pipeline flush
in_valid  input  1  beat valid
in_ready  output  1  beat accepted when in_valid and in_ready both high
in_last  input  1  marks final beat of frame
in_data  input  10*N_LANE  lane k = bits [10k+9:10k] = {j,i,h,g,f,e,d,c,b,a}, a at LSB
out_valid  output  1  frame result valid
out_ready  input  1  result consumed when out_valid and out_ready both high
out_sum  output  SUM_W  saturated frame total
out_beats  output  BEAT_W  beats in frame, saturating
out_sat  output  1  out_sum clamped during this frame

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Per-lane terms:
  - t0 = (a|b)&c&d
  - t1 = i&j
  - t2 = (e^f)|g|h
  - lane count = t0+t1+t2, range 0..3
  - beat sum = sum over lanes, range 0..3*N_LANE, sized internally with no loss.
- Pipeline:
  - S1 registers the beat sum, the last flag and a valid bit.
  - S2 adds the beat sum into the accumulator acc.
  - When S1 carries last: result registers <= acc+beat (saturated), acc and the beat counter clear, out_valid=1.
- Latency: last beat accepted at edge T, out_valid high in the cycle after edge T+1, i.e. 2 cycles.
- FSM:
  - ACCUM: in_ready=1. Accepting a beat with in_last goes to DRAIN.
  - DRAIN: in_ready=0, one cycle. Result loads, go to HOLD.
  - HOLD: in_ready=0, out_valid=1, outputs stable. On out_ready, go to ACCUM; in_ready=1 in the following cycle.
- in_ready is a combinational decode of state only; it does not depend on out_ready. in_valid while in_ready=0 is ignored.
- Saturation:
  - If acc+beat > 2^SUM_W-1, acc clamps to all-ones and the sticky sat flag sets.
  - sat and acc clear when the result is loaded.
  - The beat counter clamps at 2^BEAT_W-1.
- Single-beat frame (in_last on first beat) is legal: out_beats=1.
- Empty beats (all lanes zero) count toward out_beats and add 0.
- clr:
  - Takes effect at the next edge from any state.
  - Flushes S1, clears acc, counter, sat and out_valid; state goes to ACCUM.
  - A beat presented with clr high is dropped.
- Reset values: out_valid=0, out_sum=0, out_beats=0, out_sat=0, state=ACCUM. in_ready=1 once rst_n is high.
- Reset asserted mid-frame or in HOLD: all state is lost immediately; no result is produced.

Test Plan:
- N_LANE=4, single beat, all lanes 0x3FF, in_last=1 -> out_valid 2 cycles later; out_sum=12, out_beats=1, out_sat=0.
- 3-beat frame, lanes {0x00D,0x300,0x010,0x000} every beat -> out_sum=9, out_beats=3, out_sat=0; in_ready low from the cycle after the last beat until the result is consumed.
- SUM_W=8, 22 beats of all-ones lanes (264 total) -> out_sum=255, out_sat=1, out_beats=22; the next frame (1 beat of 0x010 in all lanes) -> out_sum=4, out_sat=0.
- Hold out_ready low 5 cycles in HOLD -> out_valid, out_sum and out_beats stable, in_ready=0, in_valid pulses ignored; after the handshake in_ready=1 the next cycle.
- clr after 2 beats of a frame -> no out_valid; a fresh 1-beat frame of 0x010 in all lanes -> out_sum=4, out_beats=1.
- Drop rst_n during HOLD -> out_valid=0 and out_sum=0 immediately (asynchronously); after release in_ready=1 and a new frame is processed normally.
